frame_buffer_local_arbiter: RTL and testbench
=============================================

Name: frame_buffer_local_arbiter

Overview:
- Two-port arbiter that shares the DDR controller local interface (23-bit word address, 32-bit data, size 1..2) between two masters.
- Port 0 (p0) is the display read master: read-only, high priority.
- Port 1 (p1) is the CPU/C2H master: read and write.
- Sits between the masters and the controller/PHY local_* port, in the phy_clk domain. It queues write data for local_wdata_req and routes returned read data back to the requester by tag.

Parameters:
MAX_P0_RUN, 4, consecutive p0 grants allowed while p1 waits before p1 is forced a grant
WFIFO_DEPTH, 4, write-data FIFO depth in beats (power of 2, >=2)
RTAG_DEPTH, 8, outstanding read-tag FIFO depth (power of 2)

Ports:
phy_clk  in  1  clock
reset_phy_clk_n  in  1  asynchronous active-low reset
local_init_done  in  1  controller calibrated/ready for traffic
local_ready  in  1  controller accepts current command
local_wdata_req  in  1  controller consumes one write beat this cycle
local_rdata_valid  in  1  read beat valid
local_rdata  in  32  read beat
local_address  out  23  command address
local_size  out  2  burst length (1 or 2)
local_read_req  out  1  read command valid
local_write_req  out  1  write command/beat valid
local_burstbegin  out  1  first beat of command
local_be  out  4  byte enables
local_wdata  out  32  head of write-data FIFO
p0_address  in  23; p0_size  in  2; p0_read  in  1
p0_waitrequest  out  1; p0_readdata  out  32; p0_readdatavalid  out  1
p1_address  in  23; p1_size  in  2; p1_read  in  1; p1_write  in  1; p1_wdata  in  32; p1_be  in  4
p1_waitrequest  out  1; p1_readdata  out  32; p1_readdatavalid  out  1
err_unexpected_rdata  out  1  sticky: rdata_valid arrived with tag FIFO empty

Behaviour:
Reset and register structure:
- Single clock. Asynchronous, active-low reset on reset_phy_clk_n.
- Reset values: all outputs 0, except p0_waitrequest and p1_waitrequest, which reset to 1. FIFOs empty; state = WAIT_INIT.

Command register:
- Registered command slot; "free" means empty, or holding a request with local_ready=1 this cycle.
- A port request is accepted in cycle N (its waitrequest=0 in N); local_*_req is asserted from N+1.
- The command is held unchanged until local_ready=1.

State machine:
- WAIT_INIT: both waitrequests high. Go to IDLE when local_init_done=1.
- IDLE: when the slot is free, grant one requester.
  - Read eligible: tag FIFO not full.
  - p1 write eligible: FIFO free space >= p1_size.
  - Winner: p0 if eligible, unless run counter == MAX_P0_RUN and p1 is eligible; then p1.
  - Load the slot with burstbegin=1. Write data/be are pushed to the write-data FIFO and the local_be register.
  - A p1 write with size 2 goes to WBURST.
- WBURST: p0 is locked out. The next accepted p1_write beat loads the slot with burstbegin=0 and pushes its data; return to IDLE. p1_read in this state is held off (waitrequest=1).
- If local_init_done drops: finish any WBURST, then go to WAIT_INIT.

Run counter:
- Increments on each p0 grant while p1 (read or write) is pending.
- Clears on any p1 grant, or in any cycle p1 is not requesting.
- Saturates at MAX_P0_RUN.

Read tags:
- On each read issue, push {port, size} to the tag FIFO.
- On local_rdata_valid: register the beat to the head tag's port (pX_readdata / pX_readdatavalid one cycle later), decrement beats, and pop on the last beat.
- rdata_valid with the tag FIFO empty: drop the beat and set err_unexpected_rdata (cleared only by reset).

Write data:
- local_wdata always shows the FIFO head; pop on local_wdata_req.
- local_wdata_req with the FIFO empty: ignored, FIFO pointers unchanged.

Boundary and width rules:
- Simultaneous push and pop are allowed at full or empty.
- p0_size or p1_size of 0 is treated as 1; size 3 is treated as 2.
- Address is passed through unchanged.

Test Plan:
- Idle-to-read: reset, init_done=1, p0 read addr 0x000100 size 2, local_ready=1 -> local_read_req=1 one cycle after accept with addr 0x000100, size 2, burstbegin=1; two rdata beats 0xA, 0xB -> p0_readdatavalid pulses twice with 0xA, 0xB, one cycle after each local_rdata_valid; p1 sees nothing.
- Starvation guard: p0 and p1 reads asserted continuously -> grant order p0,p0,p0,p0,p1, then repeats.
- Size-2 write: p1 write 0x400000, data 0x11 then 0x22, be 0xF -> write_req beat 1 with burstbegin=1, beat 2 with burstbegin=0; p0 is stalled between the beats; local_wdata equals 0x11 then 0x22 across two wdata_req pulses.
- Backpressure: local_ready=0 for 10 cycles with a command loaded -> command is stable and both waitrequests stay 1; command releases when local_ready=1.
- Full conditions: 8 outstanding reads -> ninth read is held off; write FIFO at 3/4 -> a size-2 write is held off and a size-1 write is accepted.
- Errors and reset: local_rdata_valid with no reads outstanding -> err_unexpected_rdata=1 sticky; reset asserted mid-burst -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/frame_buffer_local_arbiter_if.sv
// frame_buffer_local_arbiter_if: master ports and controller local port of the frame buffer arbiter
// The master modport drives the arbiter's inputs; the slave modport is the arbiter itself.
interface frame_buffer_local_arbiter_if;
    logic        local_init_done;
    logic        local_ready;
    logic        local_wdata_req;
    logic        local_rdata_valid;
    logic [31:0] local_rdata;
    logic [22:0] local_address;
    logic [1:0]  local_size;
    logic        local_read_req;
    logic        local_write_req;
    logic        local_burstbegin;
    logic [3:0]  local_be;
    logic [31:0] local_wdata;
    logic [22:0] p0_address;
    logic [1:0]  p0_size;
    logic        p0_read;
    logic        p0_waitrequest;
    logic [31:0] p0_readdata;
    logic        p0_readdatavalid;
    logic [22:0] p1_address;
    logic [1:0]  p1_size;
    logic        p1_read;
    logic        p1_write;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_be;
    logic        p1_waitrequest;
    logic [31:0] p1_readdata;
    logic        p1_readdatavalid;
    logic        err_unexpected_rdata;

    modport master (
        output local_init_done, local_ready, local_wdata_req, local_rdata_valid, local_rdata,
        output p0_address, p0_size, p0_read,
        output p1_address, p1_size, p1_read, p1_write, p1_wdata, p1_be,
        input  local_address, local_size, local_read_req, local_write_req, local_burstbegin,
        input  local_be, local_wdata,
        input  p0_waitrequest, p0_readdata, p0_readdatavalid,
        input  p1_waitrequest, p1_readdata, p1_readdatavalid, err_unexpected_rdata
    );

    modport slave (
        input  local_init_done, local_ready, local_wdata_req, local_rdata_valid, local_rdata,
        input  p0_address, p0_size, p0_read,
        input  p1_address, p1_size, p1_read, p1_write, p1_wdata, p1_be,
        output local_address, local_size, local_read_req, local_write_req, local_burstbegin,
        output local_be, local_wdata,
        output p0_waitrequest, p0_readdata, p0_readdatavalid,
        output p1_waitrequest, p1_readdata, p1_readdatavalid, err_unexpected_rdata
    );
endinterface

// File: rtl/frame_buffer_local_arbiter.sv
// frame_buffer_local_arbiter: shares the DDR local port between a display reader (p0) and a CPU master (p1)
// Registered command slot, write-data FIFO and read-tag FIFO routing returned beats back to their port.
module frame_buffer_local_arbiter #(
    parameter int MAX_P0_RUN  = 4,
    parameter int WFIFO_DEPTH = 4,
    parameter int RTAG_DEPTH  = 8
) (
    input logic phy_clk,
    input logic reset_phy_clk_n,
    frame_buffer_local_arbiter_if.slave bus
);
    localparam int WA = $clog2(WFIFO_DEPTH);
    localparam int TA = $clog2(RTAG_DEPTH);
    localparam int RW = $clog2(MAX_P0_RUN + 1);
    localparam logic [WA:0] WFULL = (WA + 1)'(WFIFO_DEPTH);
    localparam logic [TA:0] TFULL = (TA + 1)'(RTAG_DEPTH);

    typedef enum logic [1:0] {WAIT_INIT, IDLE, WBURST} state_t;
    state_t state;

    logic [31:0]   wmem [WFIFO_DEPTH];
    logic [WA-1:0] wrd, wwr;
    logic [WA:0]   wcnt, wspace;
    logic [1:0]    tmem [RTAG_DEPTH];
    logic [TA-1:0] trd, twr;
    logic [TA:0]   tcnt;
    logic          rbeat;
    logic [RW-1:0] run;
    logic slot_free, tag_ok, p0_big, p1_big, p1_req, p0_elig, p1_elig, idle_go;
    logic gnt0, gnt1, gnt1_wr, gnt1_rd, wpop, tpush, rv_ok, tpop;

    always_comb begin
        slot_free = !(bus.local_read_req || bus.local_write_req) || bus.local_ready;
        tag_ok = tcnt != TFULL;
        wspace = WFULL - wcnt;
        p0_big = bus.p0_size > 2'd1;
        p1_big = bus.p1_size > 2'd1;
        p1_req = bus.p1_read || bus.p1_write;
        p0_elig = bus.p0_read && tag_ok;
        // a write needs room for its whole burst; space > 1 means room for two beats
        p1_elig = bus.p1_write ? wspace > {{WA{1'b0}}, p1_big} : bus.p1_read && tag_ok;
        idle_go = state == IDLE && bus.local_init_done && slot_free;
        gnt0 = idle_go && p0_elig && !(run == RW'(MAX_P0_RUN) && p1_elig);
        gnt1 = (idle_go && p1_elig && !gnt0) || (state == WBURST && slot_free && bus.p1_write && wcnt != WFULL);
        gnt1_wr = gnt1 && bus.p1_write;
        gnt1_rd = gnt1 && !bus.p1_write;
        bus.p0_waitrequest = !gnt0;
        bus.p1_waitrequest = !gnt1;
        bus.local_wdata = wmem[wrd];
        wpop = bus.local_wdata_req && wcnt != '0;
        tpush = gnt0 || gnt1_rd;
        rv_ok = bus.local_rdata_valid && tcnt != '0;
        tpop = rv_ok && !(tmem[trd][0] && !rbeat);
    end

    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            state <= WAIT_INIT;
            bus.local_address <= '0;
            bus.local_size <= '0;
            bus.local_read_req <= 1'b0;
            bus.local_write_req <= 1'b0;
            bus.local_burstbegin <= 1'b0;
            bus.local_be <= '0;
            bus.p0_readdata <= '0;
            bus.p0_readdatavalid <= 1'b0;
            bus.p1_readdata <= '0;
            bus.p1_readdatavalid <= 1'b0;
            bus.err_unexpected_rdata <= 1'b0;
            for (int i = 0; i < WFIFO_DEPTH; i++) wmem[i] <= '0;
            for (int i = 0; i < RTAG_DEPTH; i++) tmem[i] <= '0;
            wrd <= '0;
            wwr <= '0;
            wcnt <= '0;
            trd <= '0;
            twr <= '0;
            tcnt <= '0;
            rbeat <= 1'b0;
            run <= '0;
        end else begin
            state <= state == WAIT_INIT ? (bus.local_init_done ? IDLE : WAIT_INIT)
                   : state == IDLE ? (!bus.local_init_done ? WAIT_INIT : (gnt1_wr && p1_big) ? WBURST : IDLE)
                   : gnt1 ? IDLE : WBURST;
            if (gnt0 || gnt1) begin
                bus.local_read_req <= !gnt1_wr;
                bus.local_write_req <= gnt1_wr;
                bus.local_burstbegin <= state == IDLE;
                if (state == IDLE) begin
                    bus.local_address <= gnt0 ? bus.p0_address : bus.p1_address;
                    bus.local_size <= gnt0 ? {p0_big, !p0_big} : {p1_big, !p1_big};
                end
                if (gnt1_wr) bus.local_be <= bus.p1_be;
            end else if (slot_free) begin
                bus.local_read_req <= 1'b0;
                bus.local_write_req <= 1'b0;
                bus.local_burstbegin <= 1'b0;
            end
            if (!p1_req || gnt1) run <= '0;
            else if (gnt0 && run != RW'(MAX_P0_RUN)) run <= run + 1'b1;
            if (gnt1_wr) begin
                wmem[wwr] <= bus.p1_wdata;
                wwr <= wwr + 1'b1;
            end
            if (wpop) wrd <= wrd + 1'b1;
            wcnt <= wcnt + {{WA{1'b0}}, gnt1_wr} - {{WA{1'b0}}, wpop};
            // tag = {port, two-beat}
            if (tpush) begin
                tmem[twr] <= {gnt1_rd, gnt0 ? p0_big : p1_big};
                twr <= twr + 1'b1;
            end
            if (tpop) trd <= trd + 1'b1;
            tcnt <= tcnt + {{TA{1'b0}}, tpush} - {{TA{1'b0}}, tpop};
            if (rv_ok) rbeat <= !tpop;
            bus.p0_readdatavalid <= rv_ok && !tmem[trd][1];
            bus.p1_readdatavalid <= rv_ok && tmem[trd][1];
            if (rv_ok && !tmem[trd][1]) bus.p0_readdata <= bus.local_rdata;
            if (rv_ok && tmem[trd][1]) bus.p1_readdata <= bus.local_rdata;
            if (bus.local_rdata_valid && tcnt == '0) bus.err_unexpected_rdata <= 1'b1;
        end
    end
endmodule

// File: tb/tb_frame_buffer_local_arbiter.sv
// tb_frame_buffer_local_arbiter: directed stimulus with command and read-data scoreboards
// Expected commands and read beats are queued as stimulus is driven and popped as the DUT emits them.
module tb_frame_buffer_local_arbiter;
    logic phy_clk;
    logic rst_n;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wr;
        logic [22:0] addr;
        logic [1:0]  size;
        logic        bb;
        logic [3:0]  be;
    } cmd_t;

    cmd_t        cmdq [$];
    logic [31:0] p0q [$];
    logic [31:0] p1q [$];
    cmd_t        e;

    frame_buffer_local_arbiter_if bus ();

    frame_buffer_local_arbiter dut (
        .phy_clk(phy_clk),
        .reset_phy_clk_n(rst_n),
        .bus(bus)
    );

    always #5 phy_clk = ~phy_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge phy_clk);
        #2;
    endtask

    task automatic exp_cmd(input logic wr, input logic [22:0] a, input logic [1:0] s, input logic bb, input logic [3:0] be);
        cmdq.push_back('{wr: wr, addr: a, size: s, bb: bb, be: be});
    endtask

    task automatic beat(input logic [31:0] d, input logic port);
        bus.local_rdata_valid = 1'b1;
        bus.local_rdata = d;
        if (port) p1q.push_back(d);
        else p0q.push_back(d);
        tick();
        bus.local_rdata_valid = 1'b0;
    endtask

    // command scoreboard: a command leaves the slot when it is valid with local_ready high
    always @(negedge phy_clk) begin
        if (rst_n && (bus.local_read_req || bus.local_write_req) && bus.local_ready) begin
            chk("cmd_expected", cmdq.size() != 0, 1);
            if (cmdq.size() != 0) begin
                e = cmdq.pop_front();
                chk("cmd_read_req", bus.local_read_req, !e.wr);
                chk("cmd_write_req", bus.local_write_req, e.wr);
                chk("cmd_address", bus.local_address, e.addr);
                chk("cmd_size", bus.local_size, e.size);
                chk("cmd_burstbegin", bus.local_burstbegin, e.bb);
                if (e.wr) chk("cmd_be", bus.local_be, e.be);
            end
        end
        if (rst_n && bus.p0_readdatavalid) begin
            chk("p0_rd_expected", p0q.size() != 0, 1);
            if (p0q.size() != 0) chk("p0_readdata", bus.p0_readdata, p0q.pop_front());
        end
        if (rst_n && bus.p1_readdatavalid) begin
            chk("p1_rd_expected", p1q.size() != 0, 1);
            if (p1q.size() != 0) chk("p1_readdata", bus.p1_readdata, p1q.pop_front());
        end
    end

    initial begin
        phy_clk = 1'b0;
        rst_n = 1'b1;
        bus.local_init_done = 1'b0;
        bus.local_ready = 1'b0;
        bus.local_wdata_req = 1'b0;
        bus.local_rdata_valid = 1'b0;
        bus.local_rdata = '0;
        bus.p0_address = '0;
        bus.p0_size = '0;
        bus.p0_read = 1'b0;
        bus.p1_address = '0;
        bus.p1_size = '0;
        bus.p1_read = 1'b0;
        bus.p1_write = 1'b0;
        bus.p1_wdata = '0;
        bus.p1_be = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_read_req", bus.local_read_req, 0);
        chk("rst_write_req", bus.local_write_req, 0);
        chk("rst_burstbegin", bus.local_burstbegin, 0);
        chk("rst_wdata", bus.local_wdata, 0);
        chk("rst_p0_wait", bus.p0_waitrequest, 1);
        chk("rst_p1_wait", bus.p1_waitrequest, 1);
        chk("rst_err", bus.err_unexpected_rdata, 0);
        tick(2);
        rst_n = 1'b1;
        tick();

        // idle-to-read: held off until init_done, then a size-2 read for p0
        bus.p0_read = 1'b1;
        bus.p0_address = 23'h000100;
        bus.p0_size = 2'd2;
        bus.local_ready = 1'b1;
        #1 chk("init_p0_wait", bus.p0_waitrequest, 1);
        bus.local_init_done = 1'b1;
        tick();
        #1 chk("accept_p0_wait", bus.p0_waitrequest, 0);
        exp_cmd(0, 23'h000100, 2'd2, 1, 4'h0);
        tick();
        bus.p0_read = 1'b0;
        chk("read_req_next", bus.local_read_req, 1);
        chk("read_addr_next", bus.local_address, 23'h000100);
        tick();
        chk("read_req_drop", bus.local_read_req, 0);
        beat(32'hA, 0);
        chk("p0_valid_lat", bus.p0_readdatavalid, 1);
        chk("p0_data_lat", bus.p0_readdata, 32'hA);
        beat(32'hB, 0);
        tick(2);

        // starvation guard: p0 x4 then p1 then p0 again
        bus.p0_read = 1'b1;
        bus.p0_address = 23'h000200;
        bus.p0_size = 2'd1;
        bus.p1_read = 1'b1;
        bus.p1_address = 23'h000300;
        bus.p1_size = 2'd0;
        for (int i = 0; i < 6; i++) begin
            #1 chk("starve_p0_wait", bus.p0_waitrequest, i == 4);
            chk("starve_p1_wait", bus.p1_waitrequest, i != 4);
            exp_cmd(0, i == 4 ? 23'h000300 : 23'h000200, 2'd1, 1, 4'h0);
            tick();
        end
        bus.p0_read = 1'b0;
        bus.p1_read = 1'b0;
        for (int i = 0; i < 6; i++) beat(32'h200 + i, i == 4);
        tick(2);

        // size-2 write with p0 locked out between the beats
        bus.p1_write = 1'b1;
        bus.p1_address = 23'h400000;
        bus.p1_size = 2'd2;
        bus.p1_wdata = 32'h11;
        bus.p1_be = 4'hF;
        #1 chk("wr1_p1_wait", bus.p1_waitrequest, 0);
        exp_cmd(1, 23'h400000, 2'd2, 1, 4'hF);
        tick();
        bus.p1_write = 1'b0;
        bus.p0_read = 1'b1;
        bus.p0_address = 23'h000500;
        bus.p0_size = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #1 chk("wburst_p0_wait", bus.p0_waitrequest, 1);
            tick();
        end
        bus.p1_write = 1'b1;
        bus.p1_wdata = 32'h22;
        #1 chk("wr2_p1_wait", bus.p1_waitrequest, 0);
        chk("wr2_p0_wait", bus.p0_waitrequest, 1);
        exp_cmd(1, 23'h400000, 2'd2, 0, 4'hF);
        tick();
        bus.p1_write = 1'b0;
        #1 chk("after_burst_p0_wait", bus.p0_waitrequest, 0);
        exp_cmd(0, 23'h000500, 2'd2, 1, 4'h0);
        tick();
        bus.p0_read = 1'b0;
        chk("wdata_beat1", bus.local_wdata, 32'h11);
        bus.local_wdata_req = 1'b1;
        tick();
        chk("wdata_beat2", bus.local_wdata, 32'h22);
        tick();
        bus.local_wdata_req = 1'b0;
        beat(32'h55, 0);
        beat(32'h56, 0);
        tick(2);

        // backpressure: command held while local_ready is low
        bus.local_ready = 1'b0;
        bus.p0_read = 1'b1;
        bus.p0_address = 23'h000600;
        bus.p0_size = 2'd1;
        #1 chk("bp_first_accept", bus.p0_waitrequest, 0);
        exp_cmd(0, 23'h000600, 2'd1, 1, 4'h0);
        tick();
        bus.p0_address = 23'h000700;
        bus.p1_read = 1'b1;
        bus.p1_address = 23'h000800;
        bus.p1_size = 2'd1;
        for (int i = 0; i < 10; i++) begin
            #1 chk("bp_p0_wait", bus.p0_waitrequest, 1);
            chk("bp_p1_wait", bus.p1_waitrequest, 1);
            chk("bp_addr_stable", bus.local_address, 23'h000600);
            chk("bp_req_stable", bus.local_read_req, 1);
            tick();
        end
        bus.local_ready = 1'b1;
        #1 chk("bp_release_p0", bus.p0_waitrequest, 0);
        exp_cmd(0, 23'h000700, 2'd1, 1, 4'h0);
        tick();
        bus.p0_read = 1'b0;
        #1 chk("bp_release_p1", bus.p1_waitrequest, 0);
        exp_cmd(0, 23'h000800, 2'd1, 1, 4'h0);
        tick();
        bus.p1_read = 1'b0;
        tick();
        beat(32'h61, 0);
        beat(32'h71, 0);
        beat(32'h81, 1);
        tick(2);

        // full conditions: eight outstanding reads, then a write FIFO at 3/4
        bus.p0_read = 1'b1;
        bus.p0_address = 23'h000900;
        bus.p0_size = 2'd1;
        for (int i = 0; i < 8; i++) begin
            exp_cmd(0, 23'h000900, 2'd1, 1, 4'h0);
            tick();
        end
        #1 chk("ninth_read_held", bus.p0_waitrequest, 1);
        bus.local_wdata_req = 1'b1;
        tick();
        bus.local_wdata_req = 1'b0;
        bus.p1_write = 1'b1;
        bus.p1_size = 2'd1;
        bus.p1_be = 4'h3;
        for (int i = 0; i < 3; i++) begin
            bus.p1_address = 23'h000A00 + 23'(i);
            bus.p1_wdata = 32'h30 + i;
            #1 chk("fill_p1_wait", bus.p1_waitrequest, 0);
            exp_cmd(1, 23'h000A00 + 23'(i), 2'd1, 1, 4'h3);
            tick();
        end
        bus.p1_address = 23'h000B00;
        bus.p1_size = 2'd2;
        bus.p1_wdata = 32'h40;
        #1 chk("size2_held", bus.p1_waitrequest, 1);
        tick();
        bus.p1_size = 2'd1;
        bus.p1_wdata = 32'h41;
        #1 chk("size1_accepted", bus.p1_waitrequest, 0);
        exp_cmd(1, 23'h000B00, 2'd1, 1, 4'h3);
        tick();
        bus.p1_write = 1'b0;
        #1 chk("reads_still_full", bus.p0_waitrequest, 1);
        bus.p0_read = 1'b0;
        chk("wfifo_head0", bus.local_wdata, 32'h30);
        bus.local_wdata_req = 1'b1;
        tick();
        chk("wfifo_head1", bus.local_wdata, 32'h31);
        tick();
        chk("wfifo_head2", bus.local_wdata, 32'h32);
        tick();
        chk("wfifo_head3", bus.local_wdata, 32'h41);
        tick();
        bus.local_wdata_req = 1'b0;
        for (int i = 0; i < 8; i++) beat(32'h900 + i, 0);
        tick(2);

        // unexpected read data, then reset in the middle of a write burst
        bus.local_rdata_valid = 1'b1;
        bus.local_rdata = 32'hDEAD;
        tick();
        bus.local_rdata_valid = 1'b0;
        chk("err_set", bus.err_unexpected_rdata, 1);
        tick(3);
        chk("err_sticky", bus.err_unexpected_rdata, 1);
        bus.local_ready = 1'b0;
        bus.p1_write = 1'b1;
        bus.p1_address = 23'h400010;
        bus.p1_size = 2'd2;
        bus.p1_wdata = 32'h77;
        bus.p1_be = 4'hC;
        tick();
        chk("mid_burst_write_req", bus.local_write_req, 1);
        rst_n = 1'b0;
        #1;
        cmdq.delete();
        chk("mrst_write_req", bus.local_write_req, 0);
        chk("mrst_read_req", bus.local_read_req, 0);
        chk("mrst_burstbegin", bus.local_burstbegin, 0);
        chk("mrst_address", bus.local_address, 0);
        chk("mrst_size", bus.local_size, 0);
        chk("mrst_be", bus.local_be, 0);
        chk("mrst_wdata", bus.local_wdata, 0);
        chk("mrst_p0_wait", bus.p0_waitrequest, 1);
        chk("mrst_p1_wait", bus.p1_waitrequest, 1);
        chk("mrst_err", bus.err_unexpected_rdata, 0);
        bus.p1_write = 1'b0;
        tick(2);
        chk("cmdq_empty", cmdq.size(), 0);
        chk("p0q_empty", p0q.size(), 0);
        chk("p1q_empty", p1q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
